// File: rtl/mux_n_1_scan.sv
// Registered N:1 multiplexer with a manual select mode and a round-robin scan
// mode that dwells DWELL enabled cycles on each channel.
module mux_n_1_scan #(
    parameter int W     = 8,
    parameter int SEL_W = 2,
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(2**SEL_W)*W-1:0]   I,
    input  logic [SEL_W-1:0]          S,
    input  logic                      mode,
    input  logic                      en,
    output logic [W-1:0]              Y,
    output logic [SEL_W-1:0]          ch,
    output logic                      valid,
    output logic                      wrap
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             wrap_pend;

    logic             scan_run;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] base_cnt;
    logic             last;
    logic [SEL_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend_nxt;
    logic [W-1:0]     y_nxt;

    // Scan entry behaves like a steady cycle starting at S with an empty
    // dwell count, so DWELL=1 advances straight away on the entry cycle.
    always_comb begin
        scan_run = mode & mode_q;
        sel      = scan_run ? ptr : S;
        base_cnt = scan_run ? cnt : '0;
        last     = (base_cnt == LAST_CNT);
        ptr_nxt  = last ? sel + SEL_W'(1) : sel;
        cnt_nxt  = last ? '0 : base_cnt + CNT_W'(1);
        pend_nxt = last && (sel == {SEL_W{1'b1}});
        y_nxt    = I[int'(sel)*W +: W];
    end

    // wrap_pend remembers an N-1 -> 0 advance so the wrap pulse lines up
    // with the first cycle that actually presents channel 0.
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y         <= '0;
            ch        <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            wrap_pend <= 1'b0;
        end else if (en) begin
            Y      <= y_nxt;
            ch     <= sel;
            valid  <= 1'b1;
            mode_q <= mode;
            if (mode) begin
                ptr       <= ptr_nxt;
                cnt       <= cnt_nxt;
                wrap_pend <= pend_nxt;
                wrap      <= scan_run & wrap_pend;
            end else begin
                ptr       <= S;
                cnt       <= '0;
                wrap_pend <= 1'b0;
                wrap      <= 1'b0;
            end
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Directed bench for mux_n_1_scan with W=8, SEL_W=2, DWELL=3: manual select,
// scan sequencing, enable gating, mode toggles and asynchronous reset.
module tb_mux_n_1_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] I;
    logic [1:0]  S;
    logic        mode;
    logic        en;
    logic [7:0]  Y;
    logic [1:0]  ch;
    logic        valid;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    logic [7:0] chan_val [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    mux_n_1_scan #(.W(8), .SEL_W(2), .DWELL(3), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (I),
        .S     (S),
        .mode  (mode),
        .en    (en),
        .Y     (Y),
        .ch    (ch),
        .valid (valid),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] ey, input logic [1:0] ec,
                             input logic ev, input logic ew);
        check({tag, ".Y"}, 32'(Y), 32'(ey));
        check({tag, ".ch"}, 32'(ch), 32'(ec));
        check({tag, ".valid"}, 32'(valid), 32'(ev));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic step_scan(input string tag, input logic [1:0] ec, input logic ew);
        step();
        check_out(tag, chan_val[ec], ec, 1'b1, ew);
    endtask

    initial begin
        I     = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        S     = 2'd0;
        mode  = 1'b0;
        en    = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Manual select
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            S = 2'(k);
            step();
            check_out($sformatf("manual%0d", k), chan_val[k], 2'(k), 1'b1, 1'b0);
        end

        // Asynchronous reset mid-cycle with Y=DD
        rst_n = 1'b0;
        #2;
        check_out("async_reset", 8'h00, 2'd0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;

        // Scan from channel 2
        mode = 1'b1;
        S    = 2'd2;
        step_scan("scan0", 2'd2, 1'b0);
        S = 2'd0;
        step_scan("scan1", 2'd2, 1'b0);
        step_scan("scan2", 2'd2, 1'b0);
        step_scan("scan3", 2'd3, 1'b0);
        step_scan("scan4", 2'd3, 1'b0);
        step_scan("scan5", 2'd3, 1'b0);
        step_scan("scan6", 2'd0, 1'b1);
        step_scan("scan7", 2'd0, 1'b0);
        step_scan("scan8", 2'd0, 1'b0);
        step_scan("scan9", 2'd1, 1'b0);
        step_scan("scan10", 2'd1, 1'b0);
        step_scan("scan11", 2'd1, 1'b0);

        // Data is sampled each capture: change channel 2 on the fly
        I[23:16]    = 8'h5C;
        chan_val[2] = 8'h5C;
        step_scan("live0", 2'd2, 1'b0);
        I[23:16]    = 8'hCC;
        chan_val[2] = 8'hCC;
        step_scan("live1", 2'd2, 1'b0);
        step_scan("live2", 2'd2, 1'b0);
        step_scan("gate_pre", 2'd3, 1'b0);

        // Enable gating in the middle of the ch=3 dwell
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("gate_off%0d", k), 8'hDD, 2'd3, 1'b0, 1'b0);
        end
        en = 1'b1;
        step_scan("gate_on0", 2'd3, 1'b0);
        step_scan("gate_on1", 2'd3, 1'b0);
        step_scan("gate_on2", 2'd0, 1'b1);
        step_scan("gate_on3", 2'd0, 1'b0);
        step_scan("gate_on4", 2'd0, 1'b0);
        step_scan("toggle_pre", 2'd1, 1'b0);

        // Scan -> manual -> scan restart at S=3
        mode = 1'b0;
        S    = 2'd3;
        step();
        check_out("to_manual", 8'hDD, 2'd3, 1'b1, 1'b0);
        mode = 1'b1;
        step_scan("rescan0", 2'd3, 1'b0);
        step_scan("rescan1", 2'd3, 1'b0);
        step_scan("rescan2", 2'd3, 1'b0);
        step_scan("rescan3", 2'd0, 1'b1);
        step_scan("rescan4", 2'd0, 1'b0);
        step_scan("rescan5", 2'd0, 1'b0);
        step_scan("rescan6", 2'd1, 1'b0);
        step_scan("rescan7", 2'd1, 1'b0);
        step_scan("rescan8", 2'd1, 1'b0);
        step_scan("rescan9", 2'd2, 1'b0);

        // Reset mid-scan at ch=2, held two cycles
        rst_n = 1'b0;
        #1;
        check_out("rst_scan_now", 8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check_out("rst_scan0", 8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check_out("rst_scan1", 8'h00, 2'd0, 1'b0, 1'b0);
        S     = 2'd1;
        rst_n = 1'b1;
        step_scan("post_rst0", 2'd1, 1'b0);
        S = 2'd0;
        step_scan("post_rst1", 2'd1, 1'b0);
        step_scan("post_rst2", 2'd1, 1'b0);
        step_scan("post_rst3", 2'd2, 1'b0);
        step_scan("post_rst4", 2'd2, 1'b0);
        step_scan("post_rst5", 2'd2, 1'b0);
        step_scan("post_rst6", 2'd3, 1'b0);

        // Mode raised while disabled is treated as scan entry once enabled
        mode = 1'b0;
        S    = 2'd0;
        step();
        check_out("idle_manual", 8'hAA, 2'd0, 1'b1, 1'b0);
        en   = 1'b0;
        mode = 1'b1;
        S    = 2'd3;
        step();
        check_out("idle_hold", 8'hAA, 2'd0, 1'b0, 1'b0);
        en = 1'b1;
        step_scan("late_entry0", 2'd3, 1'b0);
        step_scan("late_entry1", 2'd3, 1'b0);
        step_scan("late_entry2", 2'd3, 1'b0);
        step_scan("late_entry3", 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_1_scan.md
Name: mux_n_1_scan

Overview:
- Parametrised, registered N:1 multiplexer; the next generation of the 4:1 dataflow mux.
- Two modes:
  - Manual: the select input picks the channel.
  - Scan: an internal sequencer steps through all channels, dwelling a fixed number of enabled cycles on each.
- Used wherever several sampled buses share one downstream consumer, e.g. a display or sensor round-robin.
- Output is registered and qualified by a valid flag.

Parameters:
- W, 8, data width per channel in bits (>=1).
- SEL_W, 2, select width; channel count N = 2**SEL_W (>=1).
- DWELL, 4, enabled cycles spent on each channel in scan mode (>=1).
- CNT_W, 8, dwell counter width; must satisfy DWELL <= 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low; clears all state immediately, deasserted synchronously by the system.
- I  input  N*W  packed channel data; channel k occupies I[k*W+W-1 : k*W].
- S  input  SEL_W  channel select in manual mode; start channel when entering scan mode.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  cycle enable; when low, all state holds.
- Y  output  W  registered selected data.
- ch  output  SEL_W  registered index of the channel currently driving Y.
- valid  output  1  high for one cycle per enabled sample captured into Y.
- wrap  output  1  one-cycle pulse when scan advances from channel N-1 to 0.

Behaviour:
- Reset (rst_n low, asynchronous): Y=0, ch=0, valid=0, wrap=0; scan pointer=0; dwell counter=0; mode_q (registered mode)=0.
- Latency: one clock. Y and ch reflect inputs sampled at the previous rising edge.
- en low:
  - Y, ch, scan pointer, dwell counter and mode_q hold.
  - valid=0, wrap=0.
- Manual mode (mode=0, en=1):
  - Y<=I[S], ch<=S, valid<=1, wrap<=0.
  - Scan pointer<=S; dwell counter<=0.
- Scan entry (mode=1, mode_q=0, en=1):
  - Scan pointer loads S.
  - Y<=I[S], ch<=S, valid<=1, wrap<=0.
  - Dwell counter<=1. The entry cycle counts as the first dwell cycle.
- Scan steady (mode=1, mode_q=1, en=1):
  - Y<=I[ptr], ch<=ptr, valid<=1.
  - If dwell counter==DWELL-1: dwell counter<=0 and pointer<=ptr+1 (mod N).
    - If ptr==N-1, the pointer wraps to 0 and wrap<=1 for one cycle.
  - Otherwise dwell counter increments and wrap<=0.
  - The channel presented therefore changes every DWELL enabled cycles.
- DWELL=1: the pointer advances every enabled cycle; wrap pulses every N enabled cycles.
- N=1 (SEL_W=0 is not allowed; minimum SEL_W=1, so N=2):
  - Pointer arithmetic wraps modulo N with natural SEL_W-bit overflow.
  - No explicit compare against N is needed, since N is a power of two.
- mode_q updates only when en=1.
  - A mode toggle during en=0 takes effect at the next enabled cycle.
  - A 0->1 toggle at that point is treated as scan entry.
- Scan to manual (mode 1->0): takes effect on the same enabled edge. The pointer is overwritten by S; no wrap pulse.
- Input data I is sampled, never held: Y always carries the channel data present at the capture edge.
- Reset mid-scan: all state returns to reset values asynchronously. Scan restarts from S at the first enabled cycle after reset release with mode=1, which counts as scan entry.
- No combinational path from any input to any output.

Test Plan:
- Reset check: rst_n=0 asynchronously mid-cycle with Y nonzero -> Y=0, ch=0, valid=0, wrap=0 immediately, before the next clock edge.
- Manual select (W=8, SEL_W=2), I={8'hDD,8'hCC,8'hBB,8'hAA}, en=1, mode=0:
  - Stimulus: S=0,1,2,3 on successive cycles.
  - Response: Y=AA,BB,CC,DD one cycle later; ch=0..3; valid=1 every cycle.
- Scan (DWELL=3), mode=1, S=2, en=1 held for 12 cycles:
  - ch sequence: 2,2,2,3,3,3,0,0,0,1,1,1.
  - wrap=1 only on the first cycle ch=0.
  - Y tracks the matching I slice.
- Enable gating: during scan, drop en for 5 cycles in the middle of a dwell at ch=3 (count 1) -> valid=0, Y and ch frozen. After en returns, two more ch=3 cycles, then ch=0 with wrap=1.
- Mode toggle: in scan at ch=1, set mode=0 with S=3 -> next cycle ch=3, Y=DD, wrap=0. Set mode=1 again -> scan restarts at ch=3 with a full 3-cycle dwell.
- Reset mid-scan: assert rst_n=0 at ch=2 for 2 cycles, release with mode=1, S=1 -> outputs zero during reset. First enabled cycle after release gives ch=1, valid=1, then a full DWELL sequence follows.
